// File: rtl/nios2_oci_dct_sequencer.sv
// nios2_oci_dct_sequencer: packs 2-bit OCI trace codes into a DCT frame buffer,
// hands frames to the trace-memory writer and runs the end-of-test flush protocol.
`default_nettype none

module nios2_oci_dct_sequencer #(
  parameter int CODE_W = 2,
  parameter int SLOTS  = 15,
  parameter int CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      code_valid,
  input  logic [CODE_W-1:0]         code,
  output logic                      code_ready,
  input  logic                      flush,
  input  logic                      test_ending,
  output logic                      frame_valid,
  output logic [CODE_W*SLOTS-1:0]   frame_data,
  output logic [CNT_W-1:0]          frame_count,
  input  logic                      frame_ready,
  output logic [CODE_W*SLOTS-1:0]   dct_buffer,
  output logic [CNT_W-1:0]          dct_count,
  output logic                      test_has_ended
);

  localparam int               BUF_W = CODE_W * SLOTS;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(SLOTS);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_END_FLUSH = 2'd1,
    ST_ENDED     = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fv_q, fv_d;
  logic [BUF_W-1:0]   fdata_q, fdata_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic               ended_q, ended_d;
  logic               pend_q, pend_d;

  logic out_free;
  logic flushing;
  logic accept;
  logic transfer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      buf_q   <= '0;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      fdata_q <= '0;
      fcnt_q  <= '0;
      ended_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      fdata_q <= fdata_d;
      fcnt_q  <= fcnt_d;
      ended_q <= ended_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    out_free   = !fv_q || frame_ready;
    flushing   = ((state_q == ST_RUN) && pend_q) || (state_q == ST_END_FLUSH);
    // A full buffer may still take a code when it can transfer on the same edge.
    code_ready = (state_q == ST_RUN) && !pend_q && ((cnt_q != FULL) || out_free);
    accept     = code_valid && code_ready;
    transfer   = out_free && ((cnt_q == FULL) || (flushing && (cnt_q != '0)));

    buf_d = buf_q;
    cnt_d = cnt_q;
    if (transfer) begin
      buf_d = '0;
      cnt_d = '0;
    end
    if (accept) begin
      for (int k = 0; k < SLOTS; k++) begin
        if (cnt_d == CNT_W'(k)) begin
          buf_d[k*CODE_W +: CODE_W] = code;
        end
      end
      cnt_d = cnt_d + CNT_W'(1);
    end

    fv_d    = fv_q;
    fdata_d = fdata_q;
    fcnt_d  = fcnt_q;
    if (fv_q && frame_ready) begin
      fv_d = 1'b0;
    end
    if (transfer) begin
      fv_d    = 1'b1;
      fdata_d = buf_q;
      fcnt_d  = cnt_q;
    end

    state_d = state_q;
    pend_d  = pend_q;
    ended_d = ended_q;
    case (state_q)
      ST_RUN: begin
        if (test_ending) begin
          // END_FLUSH performs any pending flush itself.
          state_d = ST_END_FLUSH;
          pend_d  = 1'b0;
        end else if (pend_q) begin
          if (out_free) begin
            pend_d = 1'b0;
          end
        end else if (flush) begin
          pend_d = 1'b1;
        end
      end
      ST_END_FLUSH: begin
        if ((cnt_q == '0) && !fv_q) begin
          state_d = ST_ENDED;
          ended_d = 1'b1;
        end
      end
      ST_ENDED: begin
        state_d = ST_ENDED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign frame_valid    = fv_q;
  assign frame_data     = fdata_q;
  assign frame_count    = fcnt_q;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_has_ended = ended_q;

endmodule

`default_nettype wire

// File: tb/tb_nios2_oci_dct_sequencer.sv
// tb_nios2_oci_dct_sequencer: directed stimulus with a frame scoreboard drained by a
// monitor that compares every frame the writer accepts.
`default_nettype none

module tb_nios2_oci_dct_sequencer;

  logic        clk;
  logic        reset_n;
  logic        code_valid;
  logic [1:0]  code;
  logic        code_ready;
  logic        flush;
  logic        test_ending;
  logic        frame_valid;
  logic [29:0] frame_data;
  logic [3:0]  frame_count;
  logic        frame_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;

  typedef struct {
    logic [29:0] d;
    logic [3:0]  n;
  } frm_t;

  frm_t exp_q[$];
  int   n_checks;
  int   n_fails;

  nios2_oci_dct_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .code_valid     (code_valid),
    .code           (code),
    .code_ready     (code_ready),
    .flush          (flush),
    .test_ending    (test_ending),
    .frame_valid    (frame_valid),
    .frame_data     (frame_data),
    .frame_count    (frame_count),
    .frame_ready    (frame_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // n copies of code value v, slot 0 first.
  function automatic logic [29:0] fill(input logic [1:0] v, input int n);
    logic [29:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[2*k +: 2] = v;
    return r;
  endfunction

  task automatic push(input logic [29:0] d, input logic [3:0] n);
    frm_t f;
    f.d = d;
    f.n = n;
    exp_q.push_back(f);
  endtask

  task automatic monitor();
    frm_t f;
    forever begin
      @(negedge clk);
      if (reset_n && frame_valid && frame_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", {2'b0, frame_data}, 32'hDEAD);
        end else begin
          f = exp_q.pop_front();
          chk("frame_data", {2'b0, frame_data}, {2'b0, f.d});
          chk("frame_count", {28'b0, frame_count}, {28'b0, f.n});
        end
      end
    end
  endtask

  // Called and returns at posedge+1.
  task automatic send(input logic [1:0] c);
    int t;
    t = 0;
    code_valid = 1'b1;
    code = c;
    @(negedge clk);
    while (!code_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!code_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    code_valid = 1'b0;
  endtask

  task automatic pulse(input logic f, input logic te);
    flush = f;
    test_ending = te;
    @(posedge clk);
    #1;
    flush = 1'b0;
    test_ending = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [29:0] stream_exp;
    logic [29:0] held;
    int t;
    n_checks = 0;
    n_fails = 0;
    reset_n = 1'b0;
    code_valid = 1'b0;
    code = 2'b00;
    flush = 1'b0;
    test_ending = 1'b0;
    frame_ready = 1'b0;
    fork
      monitor();
      begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    #12;
    chk("rst_dct_count", {28'b0, dct_count}, 32'd0);
    chk("rst_dct_buffer", {2'b0, dct_buffer}, 32'd0);
    chk("rst_frame_valid", {31'b0, frame_valid}, 32'd0);
    chk("rst_frame_data", {2'b0, frame_data}, 32'd0);
    chk("rst_frame_count", {28'b0, frame_count}, 32'd0);
    chk("rst_ended", {31'b0, test_has_ended}, 32'd0);
    chk("rst_code_ready", {31'b0, code_ready}, 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming: slot k holds k mod 4.
    frame_ready = 1'b1;
    stream_exp = '0;
    for (int k = 0; k < 15; k++) stream_exp[2*k +: 2] = 2'(k % 4);
    push(stream_exp, 4'd15);
    for (int k = 0; k < 15; k++) send(2'(k % 4));
    t = 0;
    @(negedge clk);
    while (!frame_valid && t < 10) begin
      t++;
      @(negedge clk);
    end
    chk("stream_fv_rise", {31'b0, frame_valid}, 32'd1);
    chk("stream_count_clr", {28'b0, dct_count}, 32'd0);
    @(negedge clk);
    chk("stream_fv_one_cycle", {31'b0, frame_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Flush of an empty buffer emits nothing.
    pulse(1'b1, 1'b0);
    idle(4);
    chk("empty_flush_noframe", {31'b0, frame_valid}, 32'd0);

    // Backpressure.
    frame_ready = 1'b0;
    push(fill(2'b10, 15), 4'd15);
    push(fill(2'b01, 15), 4'd15);
    for (int k = 0; k < 15; k++) send(2'b10);
    for (int k = 0; k < 15; k++) send(2'b01);
    held = fill(2'b10, 15);
    code_valid = 1'b1;
    code = 2'b11;
    repeat (3) begin
      @(negedge clk);
      chk("bp_code_ready_low", {31'b0, code_ready}, 32'd0);
      chk("bp_count_full", {28'b0, dct_count}, 32'd15);
      chk("bp_frame_held", {2'b0, frame_data}, {2'b0, held});
    end
    @(posedge clk);
    #1;
    frame_ready = 1'b1;
    @(negedge clk);
    chk("bp_code_ready_high", {31'b0, code_ready}, 32'd1);
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    @(negedge clk);
    chk("bp_count_one", {28'b0, dct_count}, 32'd1);
    chk("bp_slot0", {2'b0, dct_buffer}, 32'd3);
    chk("bp_frame2_valid", {31'b0, frame_valid}, 32'd1);
    @(posedge clk);
    #1;
    push(30'h3, 4'd1);
    pulse(1'b1, 1'b0);
    idle(4);
    chk("bp_drained", exp_q.size(), 32'd0);

    // Partial flush.
    for (int k = 0; k < 5; k++) send(2'b11);
    push(30'h000003FF, 4'd5);
    pulse(1'b1, 1'b0);
    @(negedge clk);
    chk("pf_code_ready_pend", {31'b0, code_ready}, 32'd0);
    @(negedge clk);
    chk("pf_code_ready_back", {31'b0, code_ready}, 32'd1);
    chk("pf_frame_valid", {31'b0, frame_valid}, 32'd1);
    idle(3);
    chk("pf_drained", exp_q.size(), 32'd0);

    // Reset mid-operation.
    frame_ready = 1'b0;
    for (int k = 0; k < 22; k++) send(2'b01);
    @(negedge clk);
    chk("mid_count7", {28'b0, dct_count}, 32'd7);
    chk("mid_fv", {31'b0, frame_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_count", {28'b0, dct_count}, 32'd0);
    chk("mid_rst_buffer", {2'b0, dct_buffer}, 32'd0);
    chk("mid_rst_fv", {31'b0, frame_valid}, 32'd0);
    chk("mid_rst_fdata", {2'b0, frame_data}, 32'd0);
    chk("mid_rst_fcount", {28'b0, frame_count}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    frame_ready = 1'b1;
    idle(4);
    chk("mid_no_frame", {31'b0, frame_valid}, 32'd0);
    send(2'b10);
    chk("mid_slot0", {2'b0, dct_buffer}, 32'd2);
    chk("mid_count1", {28'b0, dct_count}, 32'd1);
    push(30'h2, 4'd1);
    pulse(1'b1, 1'b0);
    idle(3);
    chk("mid_drained", exp_q.size(), 32'd0);

    // Flush and test_ending together with a held frame and a full buffer.
    frame_ready = 1'b0;
    push(fill(2'b01, 15), 4'd15);
    push(30'h0, 4'd15);
    for (int k = 0; k < 15; k++) send(2'b01);
    for (int k = 0; k < 15; k++) send(2'b00);
    pulse(1'b1, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("sim_code_ready", {31'b0, code_ready}, 32'd0);
      chk("sim_not_ended", {31'b0, test_has_ended}, 32'd0);
      chk("sim_count_full", {28'b0, dct_count}, 32'd15);
    end
    @(posedge clk);
    #1;
    frame_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!test_has_ended && t < 10) begin
      t++;
      @(negedge clk);
    end
    chk("sim_ended", {31'b0, test_has_ended}, 32'd1);
    chk("sim_drained", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
    do_reset();
    chk("sim_reset_ended", {31'b0, test_has_ended}, 32'd0);

    // End of test.
    frame_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(2'b01);
    push(30'h15, 4'd3);
    pulse(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("eot_not_ended", {31'b0, test_has_ended}, 32'd0);
      chk("eot_code_ready", {31'b0, code_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    frame_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("eot_ended_wait", {31'b0, test_has_ended}, 32'd0);
    @(negedge clk);
    chk("eot_ended", {31'b0, test_has_ended}, 32'd1);
    @(posedge clk);
    #1;
    code_valid = 1'b1;
    code = 2'b11;
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ended_code_ready", {31'b0, code_ready}, 32'd0);
      chk("ended_sticky", {31'b0, test_has_ended}, 32'd1);
      chk("ended_no_frame", {31'b0, frame_valid}, 32'd0);
      chk("ended_count", {28'b0, dct_count}, 32'd0);
    end
    code_valid = 1'b0;
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
